// File: rtl/cpu_step_clock.sv
// Push-button CPU clock source with two modes: single-step (one fixed-width pulse
// per press) and free-running (divided clock). Also counts the cpu_clk cycles issued.
module cpu_step_clock #(
  parameter int DEBOUNCE_CYCLES  = 250000,
  parameter int STEP_HIGH_CYCLES = 4,
  parameter int RUN_HALF_CYCLES  = 12500000,
  parameter int COUNT_WIDTH      = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   btn_step_i,
  input  logic                   btn_mode_i,
  output logic                   cpu_clk_o,
  output logic                   run_mode_o,
  output logic [COUNT_WIDTH-1:0] cpu_cycles_o
);

  // state     | meaning
  // S_STOP    | cpu_clk low, waiting for a step press or run mode
  // S_STEP_HI | cpu_clk high for one single-step pulse
  // S_RUN_LO  | free-running, low half-period
  // S_RUN_HI  | free-running, high half-period (never cut short)
  typedef enum logic [1:0] {S_STOP, S_STEP_HI, S_RUN_LO, S_RUN_HI} state_t;

  localparam int PHASE_MAX = (STEP_HIGH_CYCLES > RUN_HALF_CYCLES) ? STEP_HIGH_CYCLES
                                                                   : RUN_HALF_CYCLES;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PW = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] STEP_LAST = PW'(STEP_HIGH_CYCLES - 1);
  localparam logic [PW-1:0] RUN_LAST  = PW'(RUN_HALF_CYCLES - 1);

  // Index 0 is the step button, index 1 the mode button.
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    stable_q, stable_d;
  logic [1:0]    stable_prev_q;
  logic [DW-1:0] db_cnt_q [2];
  logic [DW-1:0] db_cnt_d [2];
  logic          step_press, mode_press;

  state_t                 state_q, state_d;
  logic [PW-1:0]          phase_q, phase_d;
  logic                   run_mode_q, run_mode_d;
  logic                   cpu_clk_q, cpu_clk_d;
  logic [COUNT_WIDTH-1:0] cycles_q, cycles_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      db_cnt_q[0]   <= '0;
      db_cnt_q[1]   <= '0;
    end else begin
      sync1_q       <= {btn_mode_i, btn_step_i};
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      db_cnt_q[0]   <= db_cnt_d[0];
      db_cnt_q[1]   <= db_cnt_d[1];
    end
  end

  always_comb begin
    stable_d    = stable_q;
    db_cnt_d[0] = '0;
    db_cnt_d[1] = '0;
    for (int b = 0; b < 2; b++) begin
      if (sync2_q[b] != stable_q[b]) begin
        if (db_cnt_q[b] == DB_LAST) begin
          stable_d[b] = sync2_q[b];
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + 1'b1;
        end
      end
    end
  end

  assign step_press = stable_q[0] & ~stable_prev_q[0];
  assign mode_press = stable_q[1] & ~stable_prev_q[1];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_STOP;
      phase_q    <= '0;
      run_mode_q <= 1'b0;
      cpu_clk_q  <= 1'b0;
      cycles_q   <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      run_mode_q <= run_mode_d;
      cpu_clk_q  <= cpu_clk_d;
      cycles_q   <= cycles_d;
    end
  end

  // Phase timer counts down from the last index of the current phase to zero.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q - 1'b1;
    run_mode_d = run_mode_q ^ mode_press;
    case (state_q)
      S_STOP: begin
        phase_d = '0;
        if (run_mode_q) begin
          state_d = S_RUN_LO;
          phase_d = RUN_LAST;
        end else if (step_press && !mode_press) begin
          state_d = S_STEP_HI;
          phase_d = STEP_LAST;
        end
      end
      S_STEP_HI: begin
        if (phase_q == '0) begin
          state_d = S_STOP;
          phase_d = '0;
        end
      end
      S_RUN_LO: begin
        if (!run_mode_q) begin
          state_d = S_STOP;
          phase_d = '0;
        end else if (phase_q == '0) begin
          state_d = S_RUN_HI;
          phase_d = RUN_LAST;
        end
      end
      S_RUN_HI: begin
        if (phase_q == '0) begin
          state_d = run_mode_q ? S_RUN_LO : S_STOP;
          phase_d = run_mode_q ? RUN_LAST : '0;
        end
      end
      default: begin
        state_d = S_STOP;
        phase_d = '0;
      end
    endcase

    cpu_clk_d = (state_d == S_STEP_HI) || (state_d == S_RUN_HI);
    cycles_d  = cycles_q;
    if (cpu_clk_d && !cpu_clk_q) begin
      cycles_d = cycles_q + 1'b1;
    end
  end

  assign cpu_clk_o    = cpu_clk_q;
  assign run_mode_o   = run_mode_q;
  assign cpu_cycles_o = cycles_q;

endmodule

// File: tb/tb_cpu_step_clock.sv
// Scoreboard bench for cpu_step_clock: expected cpu_clk pulses (rise cycle, count,
// width) are queued when buttons are driven and checked as the DUT emits them.
module tb_cpu_step_clock;

  localparam int D  = 4;
  localparam int S  = 2;
  localparam int R  = 3;
  localparam int CW = 4;
  localparam int LAT = D + 3;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          btn_step_i = 1'b0;
  logic          btn_mode_i = 1'b0;
  logic          cpu_clk_o;
  logic          run_mode_o;
  logic [CW-1:0] cpu_cycles_o;

  cpu_step_clock #(
    .DEBOUNCE_CYCLES (D),
    .STEP_HIGH_CYCLES(S),
    .RUN_HALF_CYCLES (R),
    .COUNT_WIDTH     (CW)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .btn_step_i  (btn_step_i),
    .btn_mode_i  (btn_mode_i),
    .cpu_clk_o   (cpu_clk_o),
    .run_mode_o  (run_mode_o),
    .cpu_cycles_o(cpu_cycles_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int rise;
    int cnt;
    int width;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input longint got, input longint want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  // Pulse monitor, sampled on the falling edge.
  logic prev_clk = 1'b0;
  int   rise_at = 0;
  int   cur_w = 0;
  always @(negedge clk_i) begin
    if (reset_i) begin
      prev_clk = 1'b0;
    end else begin
      if (cpu_clk_o && !prev_clk) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rise", cyc, -1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rise_cycle", cyc, e.rise);
          chk("rise_count", cpu_cycles_o, e.cnt);
          rise_at = cyc;
          cur_w = e.width;
        end
      end else if (!cpu_clk_o && prev_clk) begin
        chk("high_width", cyc - rise_at, cur_w);
      end
      prev_clk = cpu_clk_o;
    end
  end

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk_i);
  endtask

  task automatic push(input int rise, input int cnt, input int width);
    exp_t e;
    e.rise = rise;
    e.cnt = cnt;
    e.width = width;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    reset_i = 1'b1;
    btn_step_i = 1'b0;
    btn_mode_i = 1'b0;
    #1;
    chk("rst_cpu_clk", cpu_clk_o, 0);
    chk("rst_run_mode", run_mode_o, 0);
    chk("rst_cycles", cpu_cycles_o, 0);
    exp_q.delete();
    repeat (3) @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
  endtask

  int c, r10, p;

  initial begin
    // Held step press: one pulse only.
    do_reset();
    c = cyc;
    push(c + LAT, 1, S);
    btn_step_i = 1'b1;
    wait_until(c + 20);
    btn_step_i = 1'b0;
    wait_until(c + 35);
    chk("hold_cycles", cpu_cycles_o, 1);
    chk("hold_clk_low", cpu_clk_o, 0);
    chk("hold_sb_empty", exp_q.size(), 0);

    // Bounce shorter than the debounce window.
    do_reset();
    btn_step_i = 1'b1;
    @(negedge clk_i);
    btn_step_i = 1'b0;
    @(negedge clk_i);
    btn_step_i = 1'b1;
    @(negedge clk_i);
    btn_step_i = 1'b0;
    c = cyc;
    wait_until(c + 30);
    chk("bounce_cycles", cpu_cycles_o, 0);
    chk("bounce_clk", cpu_clk_o, 0);

    // Run mode: 10 pulses, then leave run mode during the 10th high phase.
    do_reset();
    c = cyc;
    for (int k = 0; k < 10; k++) push(c + D + 4 + R + 2 * R * k, (k + 1) % 16, R);
    r10 = c + D + 4 + R + 2 * R * 9;
    btn_mode_i = 1'b1;
    wait_until(c + 8);
    btn_mode_i = 1'b0;
    chk("run_mode_on", run_mode_o, 1);
    p = r10 + 1 - LAT;
    wait_until(p);
    btn_mode_i = 1'b1;
    wait_until(r10 + 2);
    chk("run_last_high", cpu_clk_o, 1);
    wait_until(p + 10);
    btn_mode_i = 1'b0;
    wait_until(r10 + 25);
    chk("run_cycles", cpu_cycles_o, 10);
    chk("run_mode_off", run_mode_o, 0);
    chk("run_clk_low", cpu_clk_o, 0);
    chk("run_sb_empty", exp_q.size(), 0);

    // Reset in the middle of a step pulse.
    do_reset();
    c = cyc;
    push(c + LAT, 1, S);
    btn_step_i = 1'b1;
    wait_until(c + LAT);
    chk("midstep_high", cpu_clk_o, 1);
    #2 reset_i = 1'b1;
    #1;
    chk("async_cpu_clk", cpu_clk_o, 0);
    chk("async_run_mode", run_mode_o, 0);
    chk("async_cycles", cpu_cycles_o, 0);
    btn_step_i = 1'b0;
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
    c = cyc;
    push(c + LAT, 1, S);
    btn_step_i = 1'b1;
    wait_until(c + 12);
    btn_step_i = 1'b0;
    wait_until(c + 25);
    chk("after_rst_cycles", cpu_cycles_o, 1);
    chk("after_rst_sb", exp_q.size(), 0);

    // Step and mode pressed together from stop: only the mode toggle counts.
    do_reset();
    c = cyc;
    push(c + D + 4 + R, 1, R);
    btn_step_i = 1'b1;
    btn_mode_i = 1'b1;
    wait_until(c + 8);
    btn_step_i = 1'b0;
    btn_mode_i = 1'b0;
    chk("both_run_mode", run_mode_o, 1);
    wait_until(c + D + 4 + R + 1);
    chk("both_clk_high", cpu_clk_o, 1);
    chk("both_sb_empty", exp_q.size(), 0);

    // Counter wrap with a 4-bit counter.
    do_reset();
    for (int k = 0; k < 17; k++) begin
      c = cyc;
      push(c + LAT, (k + 1) % 16, S);
      btn_step_i = 1'b1;
      wait_until(c + 10);
      btn_step_i = 1'b0;
      wait_until(c + 20);
    end
    chk("wrap_cycles", cpu_cycles_o, 1);
    chk("wrap_sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
